prio_decoder_strobe: RTL



---
 rtl/prio_decoder_strobe.sv | 94 +++++++++
 1 files changed

// File: rtl/prio_decoder_strobe.sv
// Registered binary-to-one-hot decoder. Each accepted code is held on dec_out for DWELL cycles.
// Define PRIO_DECODER_ACTIVE_LOW_EN to drive dec_out active-low, e.g. for common-anode LEDs.
module prio_decoder_strobe #(
  parameter  int WIDTH = 64,
  parameter  int DWELL = 16,
  localparam int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDXW-1:0]  in_index,
  input  logic             in_en,
  output logic [WIDTH-1:0] dec_out,
  output logic             busy,
  output logic             done,
  output logic             range_err
);

  localparam int             CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DWELL - 1);
  localparam logic [IDXW:0]  WIDTH_L  = (IDXW + 1)'(WIDTH);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   dec_q, dec_d;
  logic               range_err_q, range_err_d;

  logic               last;
  logic               accept;
  logic               oob;
  logic [WIDTH-1:0]   code;

  assign last     = (state_q == HOLD) && (cnt_q == CNT_LAST);
  assign in_ready = (state_q == IDLE) || last;
  assign accept   = in_valid && in_ready;
  assign oob      = in_en && ({1'b0, in_index} >= WIDTH_L);

  // Out-of-range indices match no line, so they decode to blank naturally.
  always_comb begin
    code = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_en && (in_index == IDXW'(i))) code[i] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dec_d       = dec_q;
    range_err_d = range_err_q;
    if (accept) begin
      state_d = HOLD;
      cnt_d   = '0;
      dec_d   = code;
      if (oob) range_err_d = 1'b1;
    end else if (state_q == HOLD) begin
      if (last) begin
        state_d = IDLE;
        cnt_d   = '0;
        dec_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dec_q       <= '0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dec_q       <= dec_d;
      range_err_q <= range_err_d;
    end
  end

  assign busy      = (state_q == HOLD);
  assign done      = last;
  assign range_err = range_err_q;

`ifdef PRIO_DECODER_ACTIVE_LOW_EN
  assign dec_out = ~dec_q;
`else
  assign dec_out = dec_q;
`endif

endmodule
